// File: rtl/dmem_arbiter.sv
// Two-requester (cpu / loader) arbiter for a single-port data memory: 2-cycle IDLE/ISSUE access,
// 1-cycle read return, bounded loader burst lock. Define ARB_RR_EN for round-robin on contested grants.
module dmem_arbiter #(
  parameter int DW        = 16,
  parameter int AW        = 16,
  parameter int MAX_BURST = 8
) (
  input  logic          clk1,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          ldr_req,
  input  logic          ldr_lock,
  input  logic          ldr_we,
  input  logic [AW-1:0] ldr_addr,
  input  logic [DW-1:0] ldr_wdata,
  output logic          ldr_gnt,
  output logic          ldr_rvalid,
  output logic [DW-1:0] ldr_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  state_t        state_q, state_d;
  logic          own_ldr_q, own_ldr_d;   // owner tag of the latched command
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          last_ldr_q, last_ldr_d; // last_grant: 1 = LDR
  logic [CW-1:0] burst_q, burst_d;
  logic          rd_pend_q, rd_pend_d;
  logic          rd_ldr_q, rd_ldr_d;

  logic pick_ldr;
  logic contested_ldr;
  logic issue;

`ifdef ARB_RR_EN
  assign contested_ldr = ~last_ldr_q;
`else
  logic unused_last;
  assign unused_last   = last_ldr_q;
  assign contested_ldr = 1'b0;
`endif

  // A locked loader beats a waiting cpu only until the burst budget is spent.
  always_comb begin
    pick_ldr = 1'b0;
    if (!cpu_req)                                      pick_ldr = 1'b1;
    else if (!ldr_req)                                 pick_ldr = 1'b0;
    else if (ldr_lock && (burst_q < CW'(MAX_BURST)))   pick_ldr = 1'b1;
    else                                               pick_ldr = contested_ldr;
  end

  always_comb begin
    state_d    = state_q;
    own_ldr_d  = own_ldr_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    last_ldr_d = last_ldr_q;
    burst_d    = burst_q;
    rd_pend_d  = 1'b0;
    rd_ldr_d   = rd_ldr_q;
    case (state_q)
      IDLE: begin
        if (!cpu_req) burst_d = '0;
        if (cpu_req || ldr_req) begin
          state_d    = ISSUE;
          own_ldr_d  = pick_ldr;
          we_d       = pick_ldr ? ldr_we    : cpu_we;
          addr_d     = pick_ldr ? ldr_addr  : cpu_addr;
          wdata_d    = pick_ldr ? ldr_wdata : cpu_wdata;
          last_ldr_d = pick_ldr;
          if (!pick_ldr)
            burst_d = '0;
          else if (cpu_req && (burst_q < CW'(MAX_BURST)))
            burst_d = burst_q + CW'(1);
        end
      end
      ISSUE: begin
        state_d   = IDLE;
        rd_pend_d = ~we_q;
        rd_ldr_d  = own_ldr_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q    <= IDLE;
      own_ldr_q  <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      last_ldr_q <= 1'b1;
      burst_q    <= '0;
      rd_pend_q  <= 1'b0;
      rd_ldr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      own_ldr_q  <= own_ldr_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      last_ldr_q <= last_ldr_d;
      burst_q    <= burst_d;
      rd_pend_q  <= rd_pend_d;
      rd_ldr_q   <= rd_ldr_d;
    end
  end

  assign issue     = (state_q == ISSUE);
  assign busy      = issue;
  assign mem_en    = issue;
  assign mem_we    = issue & we_q;
  assign mem_addr  = issue ? addr_q  : '0;
  assign mem_wdata = issue ? wdata_q : '0;
  assign cpu_gnt   = issue & ~own_ldr_q;
  assign ldr_gnt   = issue &  own_ldr_q;

  // rdata is gated so every output reads 0 while no return is in flight.
  assign cpu_rvalid = rd_pend_q & ~rd_ldr_q;
  assign ldr_rvalid = rd_pend_q &  rd_ldr_q;
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
  assign ldr_rdata  = ldr_rvalid ? mem_rdata : '0;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural single-port memory behind it.
module tb_dmem_arbiter;
  logic        clk1 = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, ldr_req, ldr_lock, ldr_we;
  logic [15:0] cpu_addr, cpu_wdata, ldr_addr, ldr_wdata;
  logic        cpu_gnt, cpu_rvalid, ldr_gnt, ldr_rvalid;
  logic [15:0] cpu_rdata, ldr_rdata;
  logic        mem_en, mem_we, busy;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] mem [0:65535];

  dmem_arbiter dut (
    .clk1(clk1), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .ldr_req(ldr_req), .ldr_lock(ldr_lock), .ldr_we(ldr_we), .ldr_addr(ldr_addr),
    .ldr_wdata(ldr_wdata), .ldr_gnt(ldr_gnt), .ldr_rvalid(ldr_rvalid), .ldr_rdata(ldr_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk1 = ~clk1;

  always @(posedge clk1) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  typedef struct {
    bit          ldr;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [8];

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    ldr_req = 0; ldr_lock = 0; ldr_we = 0; ldr_addr = 0; ldr_wdata = 0;
  endtask

  function automatic logic any_out();
    return |{cpu_gnt, cpu_rvalid, cpu_rdata, ldr_gnt, ldr_rvalid, ldr_rdata,
             mem_en, mem_we, mem_addr, mem_wdata, busy};
  endfunction

  task automatic do_reset();
    rst = 1;
    idle_inputs();
    tick(); tick();
    chk("reset_outputs_zero", any_out(), 0);
    rst = 0;
  endtask

  // One isolated access: grant, memory command, then read return (or none for a write).
  task automatic xact(input string nm, input bit ldr, input bit we,
                      input logic [15:0] a, input logic [15:0] d, input logic [15:0] exp);
    bit got = 0;
    int t = 0;
    if (ldr) begin ldr_req = 1; ldr_we = we; ldr_addr = a; ldr_wdata = d; end
    else     begin cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = d; end
    while (!got && t < 10) begin
      tick(); t++;
      if (ldr ? ldr_gnt : cpu_gnt) got = 1;
    end
    chk({nm, "_gnt"}, got, 1);
    if (got) begin
      chk({nm, "_other_gnt"}, ldr ? cpu_gnt : ldr_gnt, 0);
      chk({nm, "_mem_we"}, mem_we, we);
      chk({nm, "_mem_addr"}, mem_addr, a);
      if (we) chk({nm, "_mem_wdata"}, mem_wdata, d);
    end
    idle_inputs();
    tick();
    chk({nm, "_rvalid"}, ldr ? ldr_rvalid : cpu_rvalid, !we);
    if (!we) chk({nm, "_rdata"}, ldr ? ldr_rdata : cpu_rdata, exp);
  endtask

  // Both requesters hold req until their quota is served; exp_cpu bit k = 1 means grant k goes to cpu.
  task automatic arb_seq(input string nm, input int nc, input int nl, input bit lock,
                         input logic [31:0] exp_cpu);
    int rc = nc;
    int rl = nl;
    int k = 0;
    int t = 0;
    cpu_req = (rc > 0); cpu_we = 0; cpu_addr = 16'h0001;
    ldr_req = (rl > 0); ldr_lock = lock; ldr_we = 1; ldr_addr = 16'h0100; ldr_wdata = 16'hC000;
    while (k < nc + nl && t < 200) begin
      tick(); t++;
      if (cpu_gnt || ldr_gnt) begin
        chk($sformatf("%s_cpu_gnt[%0d]", nm, k), cpu_gnt, exp_cpu[k]);
        chk($sformatf("%s_ldr_gnt[%0d]", nm, k), ldr_gnt, !exp_cpu[k]);
        k++;
        if (cpu_gnt) begin rc--; cpu_req = (rc > 0); end
        if (ldr_gnt) begin
          rl--; ldr_req = (rl > 0);
          ldr_addr = ldr_addr + 16'd1; ldr_wdata = ldr_wdata + 16'd1;
        end
      end
    end
    chk({nm, "_grant_count"}, k, nc + nl);
    idle_inputs();
    tick(); tick();
  endtask

  initial begin
    bit got;
    int t;
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    mem[1] = 16'h0002;
    mem_rdata = 16'h0000;

    vecs[0] = '{ldr: 1, we: 1, addr: 16'h0000, wdata: 16'h5006, exp: 16'h0000};
    vecs[1] = '{ldr: 0, we: 0, addr: 16'h0000, wdata: 16'h0000, exp: 16'h5006};
    vecs[2] = '{ldr: 0, we: 0, addr: 16'h0001, wdata: 16'h0000, exp: 16'h0002};
    vecs[3] = '{ldr: 0, we: 1, addr: 16'hFFFF, wdata: 16'hA5A5, exp: 16'h0000};
    vecs[4] = '{ldr: 1, we: 0, addr: 16'hFFFF, wdata: 16'h0000, exp: 16'hA5A5};
    vecs[5] = '{ldr: 1, we: 0, addr: 16'h0001, wdata: 16'h0000, exp: 16'h0002};
    vecs[6] = '{ldr: 1, we: 1, addr: 16'h8010, wdata: 16'h1234, exp: 16'h0000};
    vecs[7] = '{ldr: 0, we: 0, addr: 16'h8010, wdata: 16'h0000, exp: 16'h1234};

    do_reset();
    tick();

    foreach (vecs[i])
      xact($sformatf("vec%0d", i), vecs[i].ldr, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp);

    // Contested, unlocked: round-robin alternates from cpu after reset, fixed priority drains cpu first.
    do_reset();
`ifdef ARB_RR_EN
    arb_seq("contest", 3, 3, 0, 32'b010101);
`else
    arb_seq("contest", 3, 3, 0, 32'b000111);
`endif

    arb_seq("lock_nocpu", 0, 12, 1, 32'h0);
    arb_seq("lock_burst", 1, 10, 1, 32'h0000_0100);

    // Reset while a cpu read is in ISSUE: the read must never return.
    got = 0; t = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0001;
    while (!got && t < 10) begin
      tick(); t++;
      if (cpu_gnt) got = 1;
    end
    chk("rst_issue_gnt", got, 1);
    rst = 1;
    idle_inputs();
    tick();
    chk("rst_issue_outputs_zero", any_out(), 0);
    chk("rst_issue_no_rvalid", cpu_rvalid, 0);
    rst = 0;
    tick();
    chk("rst_issue_no_rvalid_late", cpu_rvalid | ldr_rvalid, 0);
    xact("post_rst_read", 0, 0, 16'h0001, 16'h0000, 16'h0002);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
